// File: rtl/text_pkg.sv
// Shared defaults for the text-mode renderer: glyph cell size, grid size,
// blank character code, cursor geometry and the pipeline control bundle.
package text_pkg;

    localparam int DEF_SYM_W = 8;
    localparam int DEF_SYM_H = 16;
    localparam int DEF_COLS  = 80;
    localparam int DEF_ROWS  = 30;
    localparam int CURSOR_H  = 2;
    localparam int FCNT_W    = 6;

    localparam logic [7:0] BLANK_CODE = 8'h20;

    typedef struct packed {
        logic in_range;
        logic cur_hit;
    } pipe_ctl_t;

endpackage

// File: rtl/text_buffer_ram.sv
// Character buffer: one write port, one registered read port, read-first
// on a same-address collision. Contents are never cleared.
module text_buffer_ram #(
    parameter int DEPTH  = 2400,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;
    logic       wr_ok;

    assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_V);
    assign rd_data = rd_data_q;

    // Non-blocking read alongside the write gives old data on a collision.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_addr] <= wr_data;
        rd_data_q <= mem_q[rd_addr];
    end

endmodule

// File: rtl/text_renderer.sv
// Three-stage text-mode pixel pipeline driving an external font ROM.
// Optional blinking underline cursor under macro TEXT_RENDERER_CURSOR_EN.
module text_renderer
    import text_pkg::*;
#(
    parameter int XY_BIT_DEPTH = 8,
    parameter int COORD_W      = 11,
    parameter int SYM_W        = DEF_SYM_W,
    parameter int SYM_H        = DEF_SYM_H,
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    localparam int ADDR_W      = $clog2(COLS * ROWS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [COORD_W-1:0]      pix_x,
    input  logic [COORD_W-1:0]      pix_y,
    input  logic                    pix_valid,
    input  logic                    frame_start,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [7:0]              wr_data,
    input  logic [6:0]              cursor_col,
    input  logic [4:0]              cursor_row,
    output logic [XY_BIT_DEPTH-1:0] sym_x,
    output logic [XY_BIT_DEPTH-1:0] sym_y,
    output logic [7:0]              sym_code,
    input  logic                    sym_pixel,
    output logic                    pixel_on,
    output logic                    pixel_valid_o
);

    localparam int GX_W  = $clog2(SYM_W);
    localparam int GY_W  = $clog2(SYM_H);
    localparam int COL_W = COORD_W - GX_W;
    localparam int ROW_W = COORD_W - GY_W;

    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [GX_W-1:0]         gx_q, gx_d;
    logic [GY_W-1:0]         gy_q, gy_d;
    pipe_ctl_t               ctl1_q, ctl1_d, ctl2_q, ctl2_d;
    logic [2:0]              vld_pipe_q, vld_pipe_d;
    logic [XY_BIT_DEPTH-1:0] sym_x_q, sym_x_d, sym_y_q, sym_y_d;
    logic                    pixel_on_q, pixel_on_d;
    logic [ADDR_W-1:0]       rd_addr;
    logic [7:0]              rd_data;
    logic                    glyph_bit;

`ifdef TEXT_RENDERER_CURSOR_EN
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    always_comb fcnt_d = frame_start ? fcnt_q + 1'b1 : fcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fcnt_q <= '0;
        else        fcnt_q <= fcnt_d;
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_col, cursor_row, frame_start};
`endif

    always_comb begin
        col_d = pix_x[COORD_W-1:GX_W];
        row_d = pix_y[COORD_W-1:GY_W];
        gx_d  = pix_x[GX_W-1:0];
        gy_d  = pix_y[GY_W-1:0];

        ctl1_d.in_range = (int'(col_d) < COLS) && (int'(row_d) < ROWS);
`ifdef TEXT_RENDERER_CURSOR_EN
        ctl1_d.cur_hit  = (int'(col_d) == int'(cursor_col)) &&
                          (int'(row_d) == int'(cursor_row)) &&
                          (int'(gy_d) >= SYM_H - CURSOR_H);
`else
        ctl1_d.cur_hit  = 1'b0;
`endif
        vld_pipe_d = {vld_pipe_q[1:0], pix_valid};

        ctl2_d  = ctl1_q;
        sym_x_d = XY_BIT_DEPTH'(gx_q);
        sym_y_d = XY_BIT_DEPTH'(gy_q);
        // Out-of-grid cells park the read on address 0; the code is masked anyway.
        rd_addr = ctl1_q.in_range ? ADDR_W'(int'(row_q) * COLS + int'(col_q)) : '0;

        sym_code = ctl2_q.in_range ? rd_data : BLANK_CODE;
`ifdef TEXT_RENDERER_CURSOR_EN
        glyph_bit = sym_pixel ^ (ctl2_q.cur_hit & ~fcnt_q[FCNT_W-1]);
`else
        glyph_bit = sym_pixel;
`endif
        pixel_on_d = glyph_bit & ctl2_q.in_range & vld_pipe_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            ctl1_q     <= '0;
            ctl2_q     <= '0;
            vld_pipe_q <= '0;
            sym_x_q    <= '0;
            sym_y_q    <= '0;
            pixel_on_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            ctl1_q     <= ctl1_d;
            ctl2_q     <= ctl2_d;
            vld_pipe_q <= vld_pipe_d;
            sym_x_q    <= sym_x_d;
            sym_y_q    <= sym_y_d;
            pixel_on_q <= pixel_on_d;
        end
    end

    text_buffer_ram #(
        .DEPTH  (COLS * ROWS),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign sym_x         = sym_x_q;
    assign sym_y         = sym_y_q;
    assign pixel_on      = pixel_on_q;
    assign pixel_valid_o = vld_pipe_q[2];

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer with a delay-line reference model and a
// small font ROM model; define TEXT_RENDERER_CURSOR_EN to cover the cursor.
module tb_text_renderer;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int NCELL = COLS * ROWS;
`ifdef TEXT_RENDERER_CURSOR_EN
    localparam bit CUR_EN = 1'b1;
`else
    localparam bit CUR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] pix_x = 11'd2047;
    logic [10:0] pix_y = 11'd0;
    logic        pix_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        wr_en = 1'b0;
    logic [11:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [6:0]  cursor_col = 7'd79;
    logic [4:0]  cursor_row = 5'd29;
    logic [7:0]  sym_x, sym_y, sym_code;
    logic        sym_pixel, pixel_on, pixel_valid_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    text_renderer dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .frame_start(frame_start), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .sym_x(sym_x), .sym_y(sym_y),
        .sym_code(sym_code), .sym_pixel(sym_pixel), .pixel_on(pixel_on),
        .pixel_valid_o(pixel_valid_o)
    );

    // Font ROM: space is empty, 'A' has a fixed shape, others derive from the code.
    function automatic logic font(input logic [7:0] c, input int x, input int y);
        logic [7:0] r;
        if (c == 8'h20) return 1'b0;
        if (c == 8'h41) begin
            r = (y == 0) ? 8'h18 : 8'h66;
            return r[7-x];
        end
        r = c;
        return r[x] ^ y[0];
    endfunction

    assign sym_pixel = font(sym_code, int'(sym_x) % 8, int'(sym_y) % 16);

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pixel seen N edges ago plus the code it fetched.
    typedef struct {
        bit rst;
        bit v;
        int x;
        int y;
        int cc;
        int cr;
    } rec_t;

    function automatic rec_t blank();
        rec_t r;
        r.rst = 1'b1; r.v = 1'b0; r.x = 0; r.y = 0; r.cc = 0; r.cr = 0;
        return r;
    endfunction

    function automatic bit in_rng(input rec_t p);
        return !p.rst && (p.x / 8 < COLS) && (p.y / 16 < ROWS);
    endfunction

    function automatic bit cur_hit(input rec_t p);
        return !p.rst && (p.x / 8 == p.cc) && (p.y / 16 == p.cr) && (p.y % 16 >= 14);
    endfunction

    rec_t       d1 = blank();
    rec_t       d2 = blank();
    logic [7:0] c2 = 8'h20;
    logic [7:0] mem [NCELL];
    int         cnt = 0;
    bit         e_vld = 1'b0;
    bit         e_on = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 = blank(); d2 = blank(); c2 = 8'h20;
            e_vld = 1'b0; e_on = 1'b0; cnt = 0;
        end else begin
            e_vld = d2.v;
            e_on  = d2.v && in_rng(d2) &&
                    (font(c2, d2.x % 8, d2.y % 16) ^ (CUR_EN && cur_hit(d2) && cnt < 32));
            if (CUR_EN && frame_start) cnt = (cnt + 1) % 64;
            c2 = in_rng(d1) ? mem[(d1.y / 16) * COLS + d1.x / 8] : 8'h20;
            d2 = d1;
            if (wr_en && int'(wr_addr) < NCELL) mem[wr_addr] = wr_data;
            d1.rst = 1'b0; d1.v = pix_valid; d1.x = int'(pix_x); d1.y = int'(pix_y);
            d1.cc = int'(cursor_col); d1.cr = int'(cursor_row);
        end
    end

    always @(negedge clk) begin
        check("model_valid", int'(pixel_valid_o), int'(e_vld));
        check("model_pixel", int'(pixel_on), int'(e_on));
        check("model_code", int'(sym_code), int'(c2));
        check("model_sym_x", int'(sym_x), d2.x % 8);
        check("model_sym_y", int'(sym_y), d2.y % 16);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input bit v);
        pix_x = 11'(x); pix_y = 11'(y); pix_valid = v;
    endtask

    // Sweep one glyph row of cell (0, y/16) and return the collected bits.
    task automatic scan_row(input int y, output logic [7:0] bits);
        bits = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) set_pix(i, y, 1'b1);
            else       set_pix(2047, 0, 1'b0);
            tick();
            if (i >= 2) bits[9-i] = pixel_on;
        end
    endtask

    logic [7:0] row_bits;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_code", int'(sym_code), 'h20);
        check("reset_pixel", int'(pixel_on), 0);
        check("reset_valid", int'(pixel_valid_o), 0);
        check("reset_sym_y", int'(sym_y), 0);
        rst_n = 1'b1;

        for (int a = 0; a < NCELL; a++) begin
            wr_en = 1'b1; wr_addr = 12'(a); wr_data = 8'(a * 7 + 3);
            tick();
        end
        wr_en = 1'b1; wr_addr = 12'd0; wr_data = 8'h41;
        tick();
        wr_en = 1'b0;

        // 'A' row 0 through cell 0
        row_bits = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) set_pix(i, 0, 1'b1);
            else       set_pix(2047, 0, 1'b0);
            tick();
            if (i == 1) check("a_code", int'(sym_code), 'h41);
            if (i >= 2) row_bits[9-i] = pixel_on;
        end
        check("a_row0", int'(row_bits), 'h18);

        // column 80 is off-grid
        set_pix(640, 0, 1'b1); tick();
        set_pix(2047, 0, 1'b0); tick();
        check("oob_code", int'(sym_code), 'h20);
        tick();
        check("oob_pixel", int'(pixel_on), 0);
        check("oob_valid", int'(pixel_valid_o), 1);

        // read-first collision on cell 5 (old content 5*7+3 = 0x26)
        set_pix(40, 0, 1'b1); tick();
        wr_en = 1'b1; wr_addr = 12'd5; wr_data = 8'h42;
        tick();
        wr_en = 1'b0;
        set_pix(2047, 0, 1'b0);
        check("rf_old_code", int'(sym_code), 'h26);
        tick();
        check("rf_new_code", int'(sym_code), 'h42);

        // ignored write beyond the grid
        wr_en = 1'b1; wr_addr = 12'd2400; wr_data = 8'h55; tick();
        wr_en = 1'b0;

        // invalid pixel over a set glyph bit
        set_pix(3, 0, 1'b0); tick();
        set_pix(2047, 0, 1'b0); tick();
        check("inv_code", int'(sym_code), 'h41);
        tick();
        check("inv_pixel", int'(pixel_on), 0);
        check("inv_valid", int'(pixel_valid_o), 0);

        // reset mid-line
        set_pix(3, 0, 1'b1);
        repeat (4) tick();
        check("pre_rst_pixel", int'(pixel_on), 1);
        rst_n = 1'b0;
        #1;
        check("rst_pixel", int'(pixel_on), 0);
        check("rst_valid", int'(pixel_valid_o), 0);
        check("rst_code", int'(sym_code), 'h20);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rel1_valid", int'(pixel_valid_o), 0);
        tick();
        check("rel2_valid", int'(pixel_valid_o), 0);
        tick();
        check("rel3_valid", int'(pixel_valid_o), 1);
        check("rel3_pixel", int'(pixel_on), 1);
        set_pix(2047, 0, 1'b0);
        repeat (3) tick();

        // mixed sweep across cells, rows and the bottom edge
        for (int k = 0; k < 200; k++) begin
            set_pix((k * 13) % 700, (k * 37) % 520, (k % 5) != 0);
            tick();
        end
        set_pix(2047, 0, 1'b0);
        repeat (3) tick();

`ifdef TEXT_RENDERER_CURSOR_EN
        cursor_col = 7'd0; cursor_row = 5'd0;
        scan_row(15, row_bits);
        check("cur_on_row15", int'(row_bits), 'h99);
        scan_row(13, row_bits);
        check("cur_row13", int'(row_bits), 'h66);
        for (int k = 0; k < 32; k++) begin
            frame_start = 1'b1; tick();
            frame_start = 1'b0; tick();
        end
        scan_row(15, row_bits);
        check("cur_off_row15", int'(row_bits), 'h66);
        cursor_col = 7'd79; cursor_row = 5'd29;
`else
        scan_row(15, row_bits);
        check("plain_row15", int'(row_bits), 'h66);
`endif
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
